// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU control codes, ALUOp and funct values, multiply FSM states.
package alu_pkg;

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_SLL     = 4'b0011;
    localparam logic [3:0] CTL_SRL     = 4'b0100;
    localparam logic [3:0] CTL_SRA     = 4'b0101;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_MULT    = 4'b1000;
    localparam logic [3:0] CTL_MULTU   = 4'b1001;
    localparam logic [3:0] CTL_MFHI    = 4'b1010;
    localparam logic [3:0] CTL_MFLO    = 4'b1011;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_XOR     = 4'b1101;
    localparam logic [3:0] CTL_SLTU    = 4'b1110;
    localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between register-read and the execute unit; slave is the execute unit side.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             valid_in;
    logic             ready;
    logic [1:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic [3:0]       ALUctl;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             busy;

    modport master (
        output valid_in, ALUOp, funct, a, b, shamt,
        input  ready, valid_out, result, ALUctl, zero, overflow, illegal, busy
    );

    modport slave (
        input  valid_in, ALUOp, funct, a, b, shamt,
        output ready, valid_out, result, ALUctl, zero, overflow, illegal, busy
    );
endinterface

// File: rtl/alu_control_dec.sv
// Combinational ALUOp/funct to ALU control code decode, plus a flag marking the unsigned variants.
// Multiply/HI/LO functs decode as legal only when ALU_MULT_EN is defined.
module alu_control_dec
    import alu_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [3:0] o_aluctl,
    output logic       o_unsigned
);

    always_comb begin
        o_aluctl   = CTL_ILLEGAL;
        o_unsigned = 1'b0;
        case (i_aluop)
            ALUOP_ADD: o_aluctl = CTL_ADD;
            ALUOP_SUB: o_aluctl = CTL_SUB;
            ALUOP_OR:  o_aluctl = CTL_OR;
            default: begin
                case (i_funct)
                    F_ADD:   o_aluctl = CTL_ADD;
                    F_ADDU:  begin o_aluctl = CTL_ADD;  o_unsigned = 1'b1; end
                    F_SUB:   o_aluctl = CTL_SUB;
                    F_SUBU:  begin o_aluctl = CTL_SUB;  o_unsigned = 1'b1; end
                    F_AND:   o_aluctl = CTL_AND;
                    F_OR:    o_aluctl = CTL_OR;
                    F_XOR:   o_aluctl = CTL_XOR;
                    F_NOR:   o_aluctl = CTL_NOR;
                    F_SLT:   o_aluctl = CTL_SLT;
                    F_SLTU:  begin o_aluctl = CTL_SLTU; o_unsigned = 1'b1; end
                    F_SLL:   o_aluctl = CTL_SLL;
                    F_SRL:   o_aluctl = CTL_SRL;
                    F_SRA:   o_aluctl = CTL_SRA;
`ifdef ALU_MULT_EN
                    F_MFHI:  o_aluctl = CTL_MFHI;
                    F_MFLO:  o_aluctl = CTL_MFLO;
                    F_MULT:  o_aluctl = CTL_MULT;
                    F_MULTU: begin o_aluctl = CTL_MULTU; o_unsigned = 1'b1; end
`endif
                    default: o_aluctl = CTL_ILLEGAL;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS execute stage: single-cycle ALU/shift ops (result one cycle after accept, back-to-back allowed) and,
// with ALU_MULT_EN, iterative mult/multu into HI/LO that holds ready low until the product is written.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clock,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);

    logic [3:0]       w_ctl;
    logic             w_uns;
    logic             w_ready;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_ovf;

    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_ctl;
    logic             r_vld;
    logic             r_zero;
    logic             r_ovf;
    logic             r_uns;
    logic             r_ill;

    alu_control_dec u_dec (
        .i_aluop    (bus.ALUOp),
        .i_funct    (bus.funct),
        .o_aluctl   (w_ctl),
        .o_unsigned (w_uns)
    );

    assign w_sum    = bus.a + bus.b;
    assign w_diff   = bus.a - bus.b;
    assign w_shamt  = bus.shamt;
    assign w_accept = bus.valid_in && w_ready;

`ifdef ALU_MULT_EN
    state_t             r_state;
    state_t             w_state_nxt;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_ready    = (r_state == IDLE) && !reset;
    assign w_is_mul   = (w_ctl == CTL_MULT) || (w_ctl == CTL_MULTU);
    // Signed multiply runs on magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_mag_a    = (w_ctl == CTL_MULT && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_mag_b    = (w_ctl == CTL_MULT && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign w_prod_fix = r_neg ? -r_prod : r_prod;
    assign bus.busy   = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_is_mul) w_state_nxt = MUL;
            MUL:     if (r_cnt == SHW'(WIDTH - 1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_accept && w_is_mul) begin
                r_cnt    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_prod   <= '0;
                r_neg    <= (w_ctl == CTL_MULT) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end else if (r_state == MUL) begin
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + SHW'(1);
            end else if (r_state == FIX) begin
                {r_hi, r_lo} <= w_prod_fix;
            end
        end
    end
`else
    assign w_ready  = !reset;
    assign w_is_mul = 1'b0;
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (w_ctl)
            CTL_AND:  w_res = bus.a & bus.b;
            CTL_OR:   w_res = bus.a | bus.b;
            CTL_XOR:  w_res = bus.a ^ bus.b;
            CTL_NOR:  w_res = ~(bus.a | bus.b);
            CTL_ADD: begin
                w_res = w_sum;
                w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            CTL_SUB: begin
                w_res = w_diff;
                w_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            CTL_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            CTL_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            CTL_SLL:  w_res = bus.b << w_shamt;
            CTL_SRL:  w_res = bus.b >> w_shamt;
            CTL_SRA:  w_res = $signed(bus.b) >>> w_shamt;
`ifdef ALU_MULT_EN
            CTL_MFHI: w_res = r_hi;
            CTL_MFLO: w_res = r_lo;
`endif
            default:  w_res = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
            r_ctl    <= CTL_AND;
            r_vld    <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_uns    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (w_accept) begin
                r_ctl <= w_ctl;
                r_ill <= (w_ctl == CTL_ILLEGAL);
                r_uns <= w_uns;
                // A multiply leaves the old result in place until the product lands.
                if (!w_is_mul) begin
                    r_result <= w_res;
                    r_zero   <= (w_res == '0);
                    r_ovf    <= w_ovf;
                    r_vld    <= 1'b1;
                end else begin
                    r_ovf <= 1'b0;
                end
            end
`ifdef ALU_MULT_EN
            if (r_state == FIX) begin
                r_result <= w_prod_fix[WIDTH-1:0];
                r_zero   <= (w_prod_fix[WIDTH-1:0] == '0);
                r_ovf    <= 1'b0;
                r_vld    <= 1'b1;
            end
`endif
        end
    end

    assign bus.ready     = w_ready;
    assign bus.valid_out = r_vld;
    assign bus.result    = r_result;
    assign bus.ALUctl    = r_ctl;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf && !r_uns;
    assign bus.illegal   = r_ill;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vectors for alu_exec_unit; expected responses queued at issue and checked by an output monitor.
module tb_alu_exec_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  ctl;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t  sb_q[$];
    string name_q[$];

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && bus.valid_out) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid_out: got result %h ctl %h expected no output", bus.result, bus.ALUctl);
            end else begin
                exp_t  e;
                string nm;
                e  = sb_q.pop_front();
                nm = name_q.pop_front();
                check_val(nm, 64'({bus.result, bus.ALUctl, bus.zero, bus.overflow, bus.illegal}), 64'(e));
            end
        end
    end

    task automatic send(input string name, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                        input logic [31:0] er, input logic [3:0] ec, input logic eo, input logic ei,
                        input bit expect_out);
        int   waits;
        exp_t e;
        waits = 0;
        @(negedge clock);
        bus.valid_in = 1'b1;
        bus.ALUOp    = op;
        bus.funct    = fn;
        bus.a        = av;
        bus.b        = bv;
        bus.shamt    = sh;
        while (!bus.ready && waits < 200) begin
            @(negedge clock);
            waits++;
        end
        if (!bus.ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept_timeout: ready %b after %0d cycles, required 1", name, bus.ready, waits);
            bus.valid_in = 1'b0;
        end else begin
            if (expect_out) begin
                e.res  = er;
                e.ctl  = ec;
                e.zero = (er == 32'd0);
                e.ovf  = eo;
                e.ill  = ei;
                sb_q.push_back(e);
                name_q.push_back(name);
            end
            @(posedge clock);
            #1 bus.valid_in = 1'b0;
        end
    endtask

    initial begin
        int waits;
        bus.valid_in = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.funct    = 6'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.shamt    = '0;

        repeat (2) @(negedge clock);
        check_val("reset_state", 64'({bus.result, bus.ALUctl, bus.valid_out, bus.zero, bus.overflow, bus.illegal, bus.busy}), 64'd0);
        check_val("ready_in_reset", 64'(bus.ready), 64'd0);
        reset = 1'b0;
        #1 check_val("ready_after_reset", 64'(bus.ready), 64'd1);

        send("add_ovf",   2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 4'b0010, 1'b1, 1'b0, 1'b1);
        send("addu_novf", 2'b10, 6'b100001, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 4'b0010, 1'b0, 1'b0, 1'b1);
        send("beq_sub",   2'b01, 6'b000000, 32'd5, 32'd5, 5'd0, 32'd0, 4'b0110, 1'b0, 1'b0, 1'b1);
        send("slt",       2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 5'd0, 32'd1, 4'b0111, 1'b0, 1'b0, 1'b1);
        send("sltu",      2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1, 5'd0, 32'd0, 4'b1110, 1'b0, 1'b0, 1'b1);
        send("sra",       2'b10, 6'b000011, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 4'b0101, 1'b0, 1'b0, 1'b1);
        send("srl",       2'b10, 6'b000010, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 4'b0100, 1'b0, 1'b0, 1'b1);
        send("sll",       2'b10, 6'b000000, 32'h0, 32'h1, 5'd31, 32'h80000000, 4'b0011, 1'b0, 1'b0, 1'b1);
        send("sub_ovf",   2'b10, 6'b100010, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 4'b0110, 1'b1, 1'b0, 1'b1);
        send("subu_novf", 2'b10, 6'b100011, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 4'b0110, 1'b0, 1'b0, 1'b1);
        send("and",       2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 4'b0000, 1'b0, 1'b0, 1'b1);
        send("ori",       2'b11, 6'b111111, 32'h000000FF, 32'h0000FF00, 5'd0, 32'h0000FFFF, 4'b0001, 1'b0, 1'b0, 1'b1);
        send("xor",       2'b10, 6'b100110, 32'h0000FF00, 32'h00000FF0, 5'd0, 32'h0000F0F0, 4'b1101, 1'b0, 1'b0, 1'b1);
        send("lw_add",    2'b00, 6'b100010, 32'd3, 32'd4, 5'd0, 32'd7, 4'b0010, 1'b0, 1'b0, 1'b1);
        send("nor",       2'b10, 6'b100111, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 4'b1100, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        @(negedge clock);
        check_val("nor_hold", 64'({bus.valid_out, bus.zero, bus.result}), {31'd0, 1'b0, 1'b0, 32'hFFFFFFFF});

        send("illegal",   2'b10, 6'b111111, 32'h12345678, 32'h9, 5'd0, 32'd0, 4'b1111, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        @(negedge clock);
        check_val("zero_hold", 64'({bus.valid_out, bus.zero, bus.illegal, bus.result}), {29'd0, 1'b0, 1'b1, 1'b1, 32'd0});

`ifdef ALU_MULT_EN
        send("mult", 2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7, 5'd0, 32'hFFFFFFEB, 4'b1000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= W; i++) begin
            @(negedge clock);
            check_val("mult_busy", 64'({bus.ready, bus.busy}), 64'b01);
        end
        @(negedge clock);
        check_val("mult_ready_back", 64'({bus.ready, bus.busy, bus.valid_out}), 64'b101);
        send("mfhi",  2'b10, 6'b010000, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 4'b1010, 1'b0, 1'b0, 1'b1);
        send("mflo",  2'b10, 6'b010010, 32'h0, 32'h0, 5'd0, 32'hFFFFFFEB, 4'b1011, 1'b0, 1'b0, 1'b1);
        send("multu", 2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2, 5'd0, 32'hFFFFFFFE, 4'b1001, 1'b0, 1'b0, 1'b1);
        send("mfhi_u_held", 2'b10, 6'b010000, 32'h0, 32'h0, 5'd0, 32'd1, 4'b1010, 1'b0, 1'b0, 1'b1);
        send("mult_zero", 2'b10, 6'b011000, 32'd0, 32'd5, 5'd0, 32'd0, 4'b1000, 1'b0, 1'b0, 1'b1);
        send("add_held", 2'b10, 6'b100000, 32'd10, 32'd20, 5'd0, 32'd30, 4'b0010, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clock);

        send("mult_abort", 2'b10, 6'b011000, 32'd5, 32'd6, 5'd0, 32'd0, 4'b1000, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1 check_val("abort_ready", 64'({bus.ready, bus.busy}), 64'b10);
        repeat (W + 5) @(negedge clock);
        send("mflo_after_abort", 2'b10, 6'b010010, 32'h0, 32'h0, 5'd0, 32'd0, 4'b1011, 1'b0, 1'b0, 1'b1);
        send("mfhi_after_abort", 2'b10, 6'b010000, 32'h0, 32'h0, 5'd0, 32'd0, 4'b1010, 1'b0, 1'b0, 1'b1);
`else
        send("mult_illegal", 2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7, 5'd0, 32'd0, 4'b1111, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val("no_mult_busy", 64'({bus.ready, bus.busy}), 64'b10);
        end
        send("mfhi_illegal", 2'b10, 6'b010000, 32'h0, 32'h0, 5'd0, 32'd0, 4'b1111, 1'b0, 1'b1, 1'b1);
        send("add_after",    2'b10, 6'b100000, 32'd10, 32'd20, 5'd0, 32'd30, 4'b0010, 1'b0, 1'b0, 1'b1);
`endif

        waits = 0;
        while (sb_q.size() > 0 && waits < 100) begin
            @(negedge clock);
            waits++;
        end
        @(negedge clock);
        check_val("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
